// File: rtl/i2s_frame_ctrl.sv
// I2S serial-side sequencer: derives SCLK/LRCLK from a programmable divider,
// shifts TX FIFO words out on SDOUT and assembles SDIN into RX FIFO words.
module i2s_frame_ctrl #(
  parameter int DIV_W = 10
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             tx_enable,
  input  logic             rx_enable,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic             tx_fifo_empty,
  input  logic [31:0]      tx_fifo_rdata,
  output logic             tx_fifo_pop,
  input  logic             rx_fifo_full,
  output logic             rx_fifo_push,
  output logic [31:0]      rx_fifo_wdata,
  output logic             SCLK,
  output logic             LRCLK,
  output logic             SDOUT,
  input  logic             SDIN,
  output logic             tx_underrun,
  output logic             rx_overrun,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] div_cnt_reg, div_l_reg, div_eff;
  logic [4:0]       bit_cnt_reg;
  logic             sclk_reg, lrclk_reg, sdout_reg;
  logic             rx_en_l_reg;
  logic [31:0]      shift_tx_reg, rx_shift_reg, rx_wdata_reg;
  logic             push_reg, ovr_reg;
  logic             en_any, tc, frame_end, rise, fall, fs, go_idle;

  assign en_any    = tx_enable | rx_enable;
  assign div_eff   = (div_ratio == '0) ? DIV_W'(1) : div_ratio;
  assign tc        = (state_reg == RUN) && (div_cnt_reg == div_l_reg - 1'b1);
  assign frame_end = tc && sclk_reg && (bit_cnt_reg == 5'd31);
  assign rise      = tc && !sclk_reg;
  assign fall      = tc && sclk_reg && (bit_cnt_reg != 5'd31);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Reset gates the frame start so pop/underrun cannot fire while held in reset.
  always_comb begin
    state_next  = state_reg;
    fs          = 1'b0;
    go_idle     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en_any && !PRESET) begin
          fs         = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (frame_end) begin
          if (en_any) begin
            fs = 1'b1;
          end else begin
            go_idle    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    tx_fifo_pop = fs && tx_enable && !tx_fifo_empty;
    tx_underrun = fs && tx_enable && tx_fifo_empty;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      div_cnt_reg  <= '0;
      div_l_reg    <= DIV_W'(1);
      bit_cnt_reg  <= '0;
      sclk_reg     <= 1'b0;
      lrclk_reg    <= 1'b0;
      sdout_reg    <= 1'b0;
      rx_en_l_reg  <= 1'b0;
      shift_tx_reg <= '0;
      rx_shift_reg <= '0;
      rx_wdata_reg <= '0;
      push_reg     <= 1'b0;
      ovr_reg      <= 1'b0;
    end else begin
      push_reg <= 1'b0;
      ovr_reg  <= 1'b0;
      if (fs) begin
        rx_en_l_reg  <= rx_enable;
        div_l_reg    <= div_eff;
        div_cnt_reg  <= '0;
        bit_cnt_reg  <= '0;
        sclk_reg     <= 1'b0;
        lrclk_reg    <= 1'b0;
        shift_tx_reg <= tx_fifo_pop ? tx_fifo_rdata : 32'h0;
        sdout_reg    <= tx_fifo_pop && tx_fifo_rdata[31];
      end else if (go_idle) begin
        div_cnt_reg <= '0;
        bit_cnt_reg <= '0;
        sclk_reg    <= 1'b0;
        lrclk_reg   <= 1'b0;
        sdout_reg   <= 1'b0;
      end else if (state_reg == RUN) begin
        div_cnt_reg <= tc ? '0 : div_cnt_reg + 1'b1;
        if (tc) sclk_reg <= !sclk_reg;
        if (rise && rx_en_l_reg) begin
          rx_shift_reg <= {rx_shift_reg[30:0], SDIN};
          // Last rising edge of the frame: hand the word over or flag the drop.
          if (bit_cnt_reg == 5'd31) begin
            if (rx_fifo_full) begin
              ovr_reg <= 1'b1;
            end else begin
              push_reg     <= 1'b1;
              rx_wdata_reg <= {rx_shift_reg[30:0], SDIN};
            end
          end
        end
        if (fall) begin
          bit_cnt_reg  <= bit_cnt_reg + 5'd1;
          shift_tx_reg <= {shift_tx_reg[30:0], 1'b0};
          sdout_reg    <= shift_tx_reg[30];
          // Upcoming bit index is bit_cnt+1; LRCLK leads each channel MSB by one bit.
          lrclk_reg    <= (bit_cnt_reg >= 5'd14) && (bit_cnt_reg <= 5'd29);
        end
      end
    end
  end

  assign SCLK          = sclk_reg;
  assign LRCLK         = lrclk_reg;
  assign SDOUT         = sdout_reg;
  assign rx_fifo_push  = push_reg;
  assign rx_overrun    = ovr_reg;
  assign rx_fifo_wdata = rx_wdata_reg;
  assign busy          = (state_reg == RUN);

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// Bench for i2s_frame_ctrl: directed and random frames checked every cycle
// against an offset-within-frame reference model.
module tb_i2s_frame_ctrl;
  localparam int DIV_W = 10;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic             tx_enable, rx_enable;
  logic [DIV_W-1:0] div_ratio;
  logic             tx_fifo_empty;
  logic [31:0]      tx_fifo_rdata;
  logic             tx_fifo_pop;
  logic             rx_fifo_full, rx_fifo_push;
  logic [31:0]      rx_fifo_wdata;
  logic             SCLK, LRCLK, SDOUT, SDIN;
  logic             tx_underrun, rx_overrun, busy;
  logic             loop_sel, sdin_drv;

  assign SDIN = loop_sel ? SDOUT : sdin_drv;
  always #5 PCLK = ~PCLK;

  i2s_frame_ctrl #(.DIV_W(DIV_W)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .tx_enable(tx_enable), .rx_enable(rx_enable), .div_ratio(div_ratio),
    .tx_fifo_empty(tx_fifo_empty), .tx_fifo_rdata(tx_fifo_rdata), .tx_fifo_pop(tx_fifo_pop),
    .rx_fifo_full(rx_fifo_full), .rx_fifo_push(rx_fifo_push), .rx_fifo_wdata(rx_fifo_wdata),
    .SCLK(SCLK), .LRCLK(LRCLK), .SDOUT(SDOUT), .SDIN(SDIN),
    .tx_underrun(tx_underrun), .rx_overrun(rx_overrun), .busy(busy)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit txe_req, rxe_req, full_req, loop_req, sdin_rand, sdin_req;
  int div_req;
  logic [31:0] txq[$];
  bit pop_seen;

  bit m_run, m_rxe, m_full;
  int m_c0, m_div;
  logic [31:0] m_word, m_rx, m_wdata;

  int n_pop, n_push, n_und, n_ovr, n_lr, last_pop_cyc, prev_pop_cyc;
  logic [31:0] last_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clr_counts();
    n_pop = 0; n_push = 0; n_und = 0; n_ovr = 0; n_lr = 0;
    last_pop_cyc = 0; prev_pop_cyc = 0; last_push = 32'h0;
  endtask

  // Expected outputs derived from the cycle offset o since the frame-start cycle:
  // half-period h=(o-1)/div, bit k=h/2, SCLK=h odd, push at o=63*div+1, next FS at o=64*div.
  task automatic model_step();
    int o, h, k;
    bit en, fs, fin;
    logic e_sclk, e_lr, e_sdo, e_busy, e_push, e_ovr, e_pop, e_und;
    en = tx_enable | rx_enable;
    fs = 0; fin = 0;
    e_sclk = 0; e_lr = 0; e_sdo = 0; e_busy = 0; e_push = 0; e_ovr = 0; e_pop = 0; e_und = 0;
    if (m_run) begin
      o = cyc - m_c0;
      h = (o - 1) / m_div;
      k = h / 2;
      e_sclk = h[0];
      e_sdo  = m_word[31-k];
      e_lr   = (k >= 15) && (k <= 30);
      e_busy = 1'b1;
      if (m_rxe && (o % (2*m_div)) == m_div) m_rx[31-k] = SDIN;
      if (o == 63*m_div) m_full = rx_fifo_full;
      if (m_rxe && o == 63*m_div + 1) begin
        e_push = !m_full;
        e_ovr  = m_full;
        if (!m_full) m_wdata = m_rx;
      end
      if (o == 64*m_div) begin
        if (en) fs = 1; else fin = 1;
      end
    end else begin
      fs = en;
    end
    if (fs) begin
      e_pop = tx_enable && !tx_fifo_empty;
      e_und = tx_enable && tx_fifo_empty;
    end
    chk("sclk", SCLK, e_sclk);
    chk("lrclk", LRCLK, e_lr);
    chk("sdout", SDOUT, e_sdo);
    chk("busy", busy, e_busy);
    chk("pop", tx_fifo_pop, e_pop);
    chk("underrun", tx_underrun, e_und);
    chk("push", rx_fifo_push, e_push);
    chk("overrun", rx_overrun, e_ovr);
    chk("wdata", rx_fifo_wdata, m_wdata);
    if (fs) begin
      m_run  = 1;
      m_c0   = cyc;
      m_div  = (div_ratio == 0) ? 1 : int'(div_ratio);
      m_rxe  = rx_enable;
      m_word = e_pop ? tx_fifo_rdata : 32'h0;
      m_rx   = 32'h0;
    end else if (fin) begin
      m_run = 0;
    end
  endtask

  task automatic cycle();
    @(posedge PCLK); #1;
    if (pop_seen && txq.size() > 0) txq.delete(0);
    tx_enable     = txe_req;
    rx_enable     = rxe_req;
    div_ratio     = DIV_W'(div_req);
    rx_fifo_full  = full_req;
    loop_sel      = loop_req;
    sdin_drv      = sdin_rand ? 1'($urandom_range(0, 1)) : sdin_req;
    tx_fifo_empty = (txq.size() == 0);
    tx_fifo_rdata = tx_fifo_empty ? 32'hDEAD_BEEF : txq[0];
    #1;
    model_step();
    pop_seen = tx_fifo_pop;
    if (tx_fifo_pop) begin prev_pop_cyc = last_pop_cyc; last_pop_cyc = cyc; n_pop++; end
    if (rx_fifo_push) begin n_push++; last_push = rx_fifo_wdata; end
    if (tx_underrun) n_und++;
    if (rx_overrun) n_ovr++;
    if (LRCLK) n_lr++;
    cyc++;
  endtask

  task automatic wait_idle(input int bound);
    int i;
    i = 0;
    while ((busy === 1'b1 || m_run) && i < bound) begin
      cycle();
      i++;
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic drop_enables();
    txe_req = 0;
    rxe_req = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1;
    tx_enable = 0; rx_enable = 0; div_ratio = '0; tx_fifo_empty = 1; tx_fifo_rdata = 32'h0;
    rx_fifo_full = 0; loop_sel = 0; sdin_drv = 0;
    txe_req = 0; rxe_req = 0; full_req = 0; loop_req = 0; sdin_rand = 0; sdin_req = 0; div_req = 0;
    m_run = 0; m_wdata = 32'h0; m_rx = 32'h0; m_word = 32'h0; pop_seen = 0;
    clr_counts();
    repeat (2) @(posedge PCLK);
    #1;
    chk("reset_outputs", {24'h0, tx_fifo_pop, rx_fifo_push, SCLK, LRCLK, SDOUT, tx_underrun, rx_overrun, busy}, 32'h0);
    chk("reset_wdata", rx_fifo_wdata, 32'h0);
    #2 PRESET = 1'b0;

    // Long idle with both enables low
    repeat (1000) cycle();

    // TX loopback at div 4, enables dropped around bit 10
    clr_counts();
    txq.push_back(32'hA5A5_3C3C);
    div_req = 4; txe_req = 1; rxe_req = 1; loop_req = 1;
    cycle();
    repeat (80) cycle();
    drop_enables();
    wait_idle(400);
    chk("lb_pops", n_pop, 1);
    chk("lb_pushes", n_push, 1);
    chk("lb_word", last_push, 32'hA5A5_3C3C);
    chk("lb_lrclk_cycles", n_lr, 128);
    loop_req = 0;

    // Underrun: TX enabled with an empty FIFO for three frames
    clr_counts();
    div_req = 3; txe_req = 1;
    cycle();
    repeat (2*192 + 100) cycle();
    drop_enables();
    wait_idle(400);
    chk("ur_count", n_und, 3);
    chk("ur_pops", n_pop, 0);

    // Overrun: RX full for two frames, then released for the third
    clr_counts();
    div_req = 2; rxe_req = 1; full_req = 1; sdin_req = 1;
    cycle();
    repeat (2*128 + 20) cycle();
    full_req = 0;
    repeat (10) cycle();
    drop_enables();
    wait_idle(400);
    chk("ov_count", n_ovr, 2);
    chk("ov_pushes", n_push, 1);
    chk("ov_word", last_push, 32'hFFFF_FFFF);
    sdin_req = 0;

    // div_ratio 4 -> 2 mid-frame takes effect at the next frame start
    clr_counts();
    txq.push_back($urandom());
    txq.push_back($urandom());
    div_req = 4; txe_req = 1; rxe_req = 1; sdin_rand = 1;
    cycle();
    repeat (50) cycle();
    div_req = 2;
    repeat (206 + 60) cycle();
    drop_enables();
    wait_idle(400);
    chk("dc_pops", n_pop, 2);
    chk("dc_pop_spacing", last_pop_cyc - prev_pop_cyc, 256);

    // div_ratio 0 and 1 both give 64-cycle frames
    for (int d = 0; d < 2; d++) begin
      clr_counts();
      repeat (3) txq.push_back($urandom());
      div_req = d; txe_req = 1; rxe_req = 0;
      cycle();
      repeat (64*2 + 10) cycle();
      drop_enables();
      wait_idle(200);
      chk("fast_pops", n_pop, 3);
      chk("fast_pop_spacing", last_pop_cyc - prev_pop_cyc, 64);
    end

    // Random enables, ratios, FIFO contents and SDIN, changed at arbitrary points
    for (int r = 0; r < 8; r++) begin
      txe_req  = 1'($urandom_range(0, 1));
      rxe_req  = 1'($urandom_range(0, 1));
      div_req  = $urandom_range(0, 5);
      full_req = 1'($urandom_range(0, 1));
      loop_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) txq.push_back($urandom());
      repeat ($urandom_range(50, 400)) cycle();
    end
    drop_enables();
    wait_idle(400);
    loop_req = 0; full_req = 0;

    // Reset in the middle of a frame aborts it with no push
    clr_counts();
    txq.push_back(32'h1234_5678);
    div_req = 2; txe_req = 1; rxe_req = 1;
    cycle();
    repeat (60) cycle();
    @(posedge PCLK);
    #3 PRESET = 1'b1;
    #1;
    chk("midrst_outputs", {24'h0, tx_fifo_pop, rx_fifo_push, SCLK, LRCLK, SDOUT, tx_underrun, rx_overrun, busy}, 32'h0);
    chk("midrst_wdata", rx_fifo_wdata, 32'h0);
    tx_enable = 0; rx_enable = 0;
    drop_enables();
    m_run = 0; m_wdata = 32'h0; pop_seen = 0;
    repeat (3) @(posedge PCLK);
    #3 PRESET = 1'b0;
    repeat (300) cycle();
    chk("midrst_no_push", n_push, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
